pocket_video_out: RTL and testbench
===================================

POCKET_VIDEO_OUT -- requirements
Module: pocket_video_out

Interface
REQ-001 SHALL have parameter EOL_ENABLE, default 1: when 1, the end-of-line word is emitted after each active line.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ce_pix  input  1  pixel enable, one clk wide, from the video colour stage.
REQ-005 hsync, vsync, hblank, vblank  input  1 each  active-high timing levels from the video colour stage.
REQ-006 r, g, b  input  8 each  pixel colour, valid on ce_pix.
REQ-007 scaler_slot  input  3  requested scaler slot; sampled only at frame start.
REQ-008 vid_rgb  output  24  {r,g,b} when active; end-of-line word or 0 otherwise.
REQ-009 vid_de  output  1  active-pixel qualifier.
REQ-010 vid_hs, vid_vs  output  1 each  start-of-line and start-of-frame pulses.
REQ-011 line_width, frame_height  output  9 each  active pixel and line counts of the last completed frame.
REQ-012 frame_start  output  1  one-clk strobe coincident with the first cycle of vid_vs.

Function
REQ-013 All outputs SHALL be registered and update only on clk cycles with ce_pix=1, so each value holds for one full pixel period.
REQ-014 Inputs SHALL be sampled on ce_pix; the resulting outputs SHALL appear on the clk cycle after that ce_pix (latency 1 clk).
REQ-015 active = ~hblank & ~vblank; vid_de SHALL equal active; vid_rgb = {r,g,b} when active.
REQ-016 A rising edge SHALL be detected by comparing the sample against a history register updated on ce_pix.
REQ-017 On a vsync rising edge, vid_vs SHALL assert for exactly one pixel period.
REQ-018 On an hsync rising edge, vid_hs SHALL assert for exactly one pixel period.
REQ-019 When hsync and vsync rise on the same ce_pix, vid_vs SHALL be emitted first and vid_hs SHALL be deferred by one pixel period; vid_hs and vid_vs SHALL never be high together.
REQ-020 A deferred vid_hs SHALL be dropped if a new hsync edge arrives in the deferral slot, so only one pulse is emitted.
REQ-021 At a vsync rising edge, slot_q SHALL latch scaler_slot; mid-frame changes of scaler_slot SHALL have no effect.
REQ-022 With EOL_ENABLE=1, on the first pixel period after active falls (1->0), vid_rgb SHALL equal {10'd0, slot_q, 11'd0} with vid_de=0.
REQ-023 In every other non-active period, vid_rgb SHALL be 24'h000000.
REQ-024 Pixel counter: +1 per active ce_pix, cleared at each hblank rising edge, saturating at 511.
REQ-025 Line counter: +1 per active->inactive transition, saturating at 511.
REQ-026 At a vsync rising edge, line_width SHALL load the pixel count of the last completed line and frame_height the line count; the line counter SHALL then clear.
REQ-027 If a frame has no active lines, the vsync edge SHALL load frame_height=0 and SHALL leave line_width unchanged.
REQ-028 ce_pix=0 cycles SHALL leave all state unchanged.

Reset
REQ-029 While reset=1, all outputs and counters SHALL be 0, slot_q SHALL be 0, and any deferred hs SHALL be cleared.
REQ-030 While reset=1, the history registers SHALL load the current hsync, vsync and active levels every clk, so a level already high at release produces no edge.
REQ-031 Reset asserted mid-line SHALL take effect on the next clk regardless of ce_pix; after release, output resumes from the next ce_pix.

Verification
REQ-032 Feed 256 active pixels per line for 240 lines, then a vsync edge -> line_width=256, frame_height=240, and frame_start is high for 1 clk.
REQ-033 hsync and vsync rise on the same ce_pix -> vid_vs is high for pixel period N and vid_hs for N+1; the two are never high together.
REQ-034 scaler_slot=5 at the vsync edge, changed to 2 mid-frame -> each EOL word equals 24'h002800 for the whole frame.
REQ-035 ce_pix every 4 clk, r=8'hAB g=8'hCD b=8'hEF while active -> vid_rgb=24'hABCDEF with vid_de=1, held for 4 clk and delayed 1 clk.
REQ-036 Hold hsync high through reset release -> no vid_hs until hsync falls and rises again.
REQ-037 Drive 600 active ce_pix cycles with no hblank -> the pixel counter saturates at 511, and the next vsync edge loads line_width=511.

Source files
------------

// File: rtl/pocket_video_out.sv
// Pixel-rate video output stage: registers colour and timing on ce_pix, turns sync
// levels into start-of-line/frame pulses, and measures the active raster size.
module pocket_video_out #(
  parameter int EOL_ENABLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic [2:0]  scaler_slot,
  output logic [23:0] vid_rgb,
  output logic        vid_de,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic [8:0]  line_width,
  output logic [8:0]  frame_height,
  output logic        frame_start
);

  logic       r_hs_hist;
  logic       r_vs_hist;
  logic       r_hb_hist;
  logic       r_act_hist;
  logic       r_hs_defer;
  logic [2:0] r_slot;
  logic [8:0] r_pix_cnt;
  logic [8:0] r_line_cnt;
  logic [8:0] r_last_width;

  logic       w_active;
  logic       w_hs_rise;
  logic       w_vs_rise;
  logic       w_hb_rise;
  logic       w_act_fall;
  logic       w_hs_want;
  logic [8:0] w_line_eff;
  logic [8:0] w_width_eff;
  logic [23:0] w_eol;

  assign w_active   = ~hblank & ~vblank;
  assign w_hs_rise  = hsync & ~r_hs_hist;
  assign w_vs_rise  = vsync & ~r_vs_hist;
  assign w_hb_rise  = hblank & ~r_hb_hist;
  assign w_act_fall = r_act_hist & ~w_active;
  // A pending (deferred) hs and a fresh hs edge merge into a single pulse.
  assign w_hs_want  = w_hs_rise | r_hs_defer;

  // Line that completes on this very sample still counts toward the frame.
  assign w_line_eff  = (w_act_fall && r_line_cnt != 9'd511) ? r_line_cnt + 9'd1 : r_line_cnt;
  assign w_width_eff = w_act_fall ? r_pix_cnt : r_last_width;
  assign w_eol       = {10'd0, r_slot, 11'd0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_hist    <= hsync;
      r_vs_hist    <= vsync;
      r_hb_hist    <= hblank;
      r_act_hist   <= w_active;
      r_hs_defer   <= 1'b0;
      r_slot       <= 3'd0;
      r_pix_cnt    <= 9'd0;
      r_line_cnt   <= 9'd0;
      r_last_width <= 9'd0;
      vid_rgb      <= 24'd0;
      vid_de       <= 1'b0;
      vid_hs       <= 1'b0;
      vid_vs       <= 1'b0;
      line_width   <= 9'd0;
      frame_height <= 9'd0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= ce_pix & w_vs_rise;
      if (ce_pix) begin
        r_hs_hist  <= hsync;
        r_vs_hist  <= vsync;
        r_hb_hist  <= hblank;
        r_act_hist <= w_active;

        vid_vs     <= w_vs_rise;
        vid_hs     <= w_hs_want & ~w_vs_rise;
        r_hs_defer <= w_hs_want & w_vs_rise;
        vid_de     <= w_active;

        if (w_active)
          vid_rgb <= {r, g, b};
        else if (EOL_ENABLE != 0 && r_act_hist)
          vid_rgb <= w_eol;
        else
          vid_rgb <= 24'd0;

        if (w_hb_rise)
          r_pix_cnt <= 9'd0;
        else if (w_active && r_pix_cnt != 9'd511)
          r_pix_cnt <= r_pix_cnt + 9'd1;

        if (w_act_fall)
          r_last_width <= r_pix_cnt;

        if (w_vs_rise) begin
          r_slot       <= scaler_slot;
          frame_height <= w_line_eff;
          if (w_line_eff != 9'd0)
            line_width <= w_width_eff;
          r_line_cnt   <= 9'd0;
        end else begin
          r_line_cnt   <= w_line_eff;
        end
      end
    end
  end

endmodule

// File: tb/tb_pocket_video_out.sv
// Directed and randomized bench for pocket_video_out with a trace-level reference
// model of the expected pixel-period outputs.
module tb_pocket_video_out;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic        hsync = 1'b0, vsync = 1'b0, hblank = 1'b1, vblank = 1'b1;
  logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
  logic [2:0]  scaler_slot = 3'd0;
  logic [23:0] vid_rgb;
  logic        vid_de, vid_hs, vid_vs, frame_start;
  logic [8:0]  line_width, frame_height;

  pocket_video_out #(.EOL_ENABLE(1)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .r(r), .g(g), .b(b), .scaler_slot(scaler_slot),
    .vid_rgb(vid_rgb), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .line_width(line_width), .frame_height(frame_height), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: previous sampled levels plus raster bookkeeping.
  logic m_hs, m_vs, m_hb, m_act, m_pend;
  int   m_slot, m_pix, m_lines, m_lastw;
  logic [23:0] e_rgb;
  logic e_de, e_hs, e_vs;
  int   e_w, e_h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int sat(input int v);
    return (v > 511) ? 511 : v;
  endfunction

  task automatic model_sample();
    logic act, hs_rise, vs_rise, want;
    act     = !hblank && !vblank;
    hs_rise = hsync && !m_hs;
    vs_rise = vsync && !m_vs;
    want    = hs_rise || m_pend;
    e_vs    = vs_rise;
    e_hs    = want && !vs_rise;
    m_pend  = want && vs_rise;
    e_de    = act;
    if (act)        e_rgb = {r, g, b};
    else if (m_act) e_rgb = 24'(m_slot * 2048);
    else            e_rgb = 24'd0;
    if (m_act && !act) begin
      m_lines = sat(m_lines + 1);
      m_lastw = m_pix;
    end
    if (hblank && !m_hb) m_pix = 0;
    else if (act)        m_pix = sat(m_pix + 1);
    if (vs_rise) begin
      e_h = m_lines;
      if (m_lines != 0) e_w = m_lastw;
      m_lines = 0;
      m_slot  = scaler_slot;
    end
    m_hs = hsync; m_vs = vsync; m_hb = hblank; m_act = act;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    ce_pix = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk("rst_rgb", vid_rgb, 0);
      chk("rst_ctl", {vid_de, vid_hs, vid_vs, frame_start}, 0);
      chk("rst_dim", {line_width, frame_height}, 0);
    end
    m_hs = hsync; m_vs = vsync; m_hb = hblank; m_act = !hblank && !vblank;
    m_pend = 0; m_slot = 0; m_pix = 0; m_lines = 0; m_lastw = 0;
    e_rgb = 0; e_de = 0; e_hs = 0; e_vs = 0; e_w = 0; e_h = 0;
    reset = 1'b0;
  endtask

  task automatic step(input logic hs, input logic vs, input logic hb, input logic vb,
                      input logic [23:0] rgb, input logic [2:0] sl, input int gap);
    hsync = hs; vsync = vs; hblank = hb; vblank = vb;
    {r, g, b} = rgb; scaler_slot = sl;
    ce_pix = 1'b1;
    model_sample();
    @(posedge clk); #1;
    ce_pix = 1'b0;
    chk("rgb", vid_rgb, e_rgb);
    chk("de", vid_de, e_de);
    chk("hs", vid_hs, e_hs);
    chk("vs", vid_vs, e_vs);
    chk("hs_vs_excl", vid_hs & vid_vs, 0);
    chk("fs", frame_start, e_vs);
    chk("width", line_width, e_w);
    chk("height", frame_height, e_h);
    for (int i = 1; i < gap; i++) begin
      @(posedge clk); #1;
      chk("hold_rgb", vid_rgb, e_rgb);
      chk("hold_sync", {vid_de, vid_hs, vid_vs}, {e_de, e_hs, e_vs});
      chk("fs_one_clk", frame_start, 0);
    end
  endtask

  logic [23:0] rgb_v;

  initial begin
    do_reset(3);
    $display("step: reset");

    // Full 256x240 frame, 2-pixel hblank with hsync in it.
    step(0, 1, 1, 1, 24'd0, 3'd1, 2);
    step(0, 0, 1, 1, 24'd0, 3'd1, 1);
    for (int ln = 0; ln < 240; ln++) begin
      for (int px = 0; px < 256; px++) begin
        rgb_v = 24'($urandom);
        step(0, 0, 0, 0, rgb_v, 3'd1, 1);
      end
      step(0, 0, 1, 0, 24'd0, 3'd1, 1);
      step(1, 0, 1, 0, 24'd0, 3'd1, 1);
    end
    step(0, 0, 1, 1, 24'd0, 3'd1, 1);
    step(0, 1, 1, 1, 24'd0, 3'd5, 3);
    chk("frame_width_256", line_width, 256);
    chk("frame_height_240", frame_height, 240);
    $display("step: 256x240 frame width=%0d height=%0d", line_width, frame_height);

    // Slot 5 latched at the vsync edge above; changing it mid-frame must not matter.
    step(0, 0, 1, 1, 24'd0, 3'd2, 1);
    for (int ln = 0; ln < 3; ln++) begin
      for (int px = 0; px < 8; px++) step(0, 0, 0, 0, 24'h123456, 3'd2, 1);
      step(0, 0, 1, 0, 24'd0, 3'd2, 1);
      chk("eol_word", vid_rgb, 24'h002800);
      chk("eol_de", vid_de, 0);
      step(1, 0, 1, 0, 24'd0, 3'd2, 1);
      chk("post_eol_zero", vid_rgb, 0);
    end
    $display("step: eol word slot 5");

    // Coincident hsync and vsync edges: vs first, hs one period later.
    step(0, 0, 1, 1, 24'd0, 3'd2, 1);
    step(1, 1, 1, 1, 24'd0, 3'd2, 2);
    chk("coinc_vs_n", {vid_vs, vid_hs}, 2'b10);
    step(1, 1, 1, 1, 24'd0, 3'd2, 2);
    chk("coinc_hs_n1", {vid_vs, vid_hs}, 2'b01);
    step(1, 1, 1, 1, 24'd0, 3'd2, 2);
    chk("coinc_idle", {vid_vs, vid_hs}, 2'b00);
    $display("step: coincident hs/vs");

    // Slow pixel clock: one ce every 4 clk.
    step(0, 0, 1, 1, 24'd0, 3'd2, 4);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 24'hABCDEF, 3'd2, 4);
      chk("slow_rgb", vid_rgb, 24'hABCDEF);
      chk("slow_de", vid_de, 1);
    end
    step(0, 0, 1, 0, 24'd0, 3'd2, 4);
    $display("step: ce every 4 clk");

    // hsync held high through reset release.
    hsync = 1'b1;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 1, 24'd0, 3'd0, 1);
      chk("hs_held_no_pulse", vid_hs, 0);
    end
    step(0, 0, 1, 1, 24'd0, 3'd0, 1);
    step(1, 0, 1, 1, 24'd0, 3'd0, 1);
    chk("hs_new_edge", vid_hs, 1);
    $display("step: hsync held through reset");

    // 600 active pixels without hblank saturate the pixel counter.
    for (int i = 0; i < 600; i++) step(0, 0, 0, 0, 24'($urandom), 3'd0, 1);
    step(0, 0, 1, 1, 24'd0, 3'd0, 1);
    step(0, 1, 1, 1, 24'd0, 3'd0, 1);
    chk("sat_width_511", line_width, 511);
    chk("sat_height_1", frame_height, 1);
    $display("step: pixel counter saturation width=%0d", line_width);

    // Random levels with occasional toggles and a mid-run reset.
    begin
      logic hs, vs, hb, vb;
      hs = 0; vs = 0; hb = 1; vb = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) hs = ~hs;
        if ($urandom_range(0, 15) == 0) vs = ~vs;
        if ($urandom_range(0, 4) == 0) hb = ~hb;
        if ($urandom_range(0, 20) == 0) vb = ~vb;
        if (i == 300) begin
          hsync = hs; vsync = vs; hblank = hb; vblank = vb;
          do_reset(2);
        end
        step(hs, vs, hb, vb, 24'($urandom), 3'($urandom), $urandom_range(1, 3));
      end
    end
    $display("step: random sequence");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
